ulpi_link_fsm: RTL and testbench

ULPI_LINK_FSM -- requirements
Module: ulpi_link_fsm

---
 rtl/ulpi_link_fsm.sv | 178 +++++++++++++++++
 tb/tb_ulpi_link_fsm.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_link_fsm.sv
// ULPI link-side controller: bus turnaround, RX CMD / RX data capture and
// a single-packet transmitter (TX CMD byte followed by TX_BYTES payload bytes).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | link owns the bus, nothing on it; launches a pending packet
// TURN     | bus turnaround after a dir edge, bus ignored / driven 0x00
// RX       | PHY owns the bus; nxt=0 -> RX CMD byte, nxt=1 -> data byte
// TX_CMD   | drive {4'b0100, pid} until PHY accepts with nxt
// TX_DATA  | drive payload byte[index], advance on nxt
// TX_STP   | one cycle of stp with 0x00, packet complete
module ulpi_link_fsm #(
   parameter int TX_BYTES   = 66,
   parameter int TURNAROUND = 1
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  dir,
   input  logic                  nxt,
   input  logic [7:0]            data_in,
   output logic [7:0]            data_out,
   output logic                  stp,
   input  logic                  shift_out,
   input  logic [3:0]            tx_pid,
   input  logic [TX_BYTES*8-1:0] internal_data_in,
   output logic                  tx_busy,
   output logic                  tx_done,
   output logic                  tx_aborted,
   output logic                  new_byte,
   output logic [7:0]            internal_data_out,
   output logic [7:0]            rx_cmd,
   output logic                  rx_cmd_valid,
   output logic                  rx_active
);

   localparam int IW = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX  = IW'(TX_BYTES - 1);
   localparam logic [1:0]    TURN_LOAD = 2'(TURNAROUND - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_TURN    = 3'd1;
   localparam logic [2:0] S_RX      = 3'd2;
   localparam logic [2:0] S_TX_CMD  = 3'd3;
   localparam logic [2:0] S_TX_DATA = 3'd4;
   localparam logic [2:0] S_TX_STP  = 3'd5;

   logic [2:0]            state;
   logic                  dir_q;
   logic [1:0]            turn_cnt;
   logic [IW-1:0]         idx;
   logic                  pending;
   logic [3:0]            pid_q;
   logic [TX_BYTES*8-1:0] payload_q;
   logic [7:0]            tx_byte;
   logic                  dir_edge;
   logic                  in_tx;
   logic                  accept;

   assign dir_edge = dir ^ dir_q;
   assign in_tx    = (state == S_TX_CMD) || (state == S_TX_DATA) || (state == S_TX_STP);
   // A new request is only taken when the single request slot is free and
   // no packet is on the wire.
   assign accept   = shift_out && !pending && !in_tx;

   // Payload byte selected by the transmit index; byte 0 sits in the MSBs.
   always_comb begin
      tx_byte = 8'h00;
      for (int i = 0; i < TX_BYTES; i++) begin
         if (idx == IW'(i)) tx_byte = payload_q[(TX_BYTES-1-i)*8 +: 8];
      end
   end

   // Outputs that are pure functions of the current state.
   always_comb begin
      data_out = 8'h00;
      case (state)
         S_TX_CMD:  data_out = {4'b0100, pid_q};
         S_TX_DATA: data_out = tx_byte;
         default:   data_out = 8'h00;
      endcase
      stp       = (state == S_TX_STP);
      tx_done   = (state == S_TX_STP);
      rx_active = (state == S_RX);
      tx_busy   = pending || in_tx;
   end

   // Link state machine, request slot, turnaround timer and RX capture.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state             <= S_IDLE;
         dir_q             <= 1'b0;
         turn_cnt          <= 2'd0;
         idx               <= '0;
         pending           <= 1'b0;
         pid_q             <= 4'h0;
         payload_q         <= '0;
         tx_aborted        <= 1'b0;
         new_byte          <= 1'b0;
         rx_cmd_valid      <= 1'b0;
         rx_cmd            <= 8'h00;
         internal_data_out <= 8'h00;
      end else begin
         dir_q        <= dir;
         tx_aborted   <= 1'b0;
         new_byte     <= 1'b0;
         rx_cmd_valid <= 1'b0;

         if (accept) begin
            pending   <= 1'b1;
            pid_q     <= tx_pid;
            payload_q <= internal_data_in;
         end

         case (state)
            S_IDLE: begin
               if (dir_edge) begin
                  state    <= S_TURN;
                  turn_cnt <= TURN_LOAD;
               end else if (pending && !dir) begin
                  state   <= S_TX_CMD;
                  pending <= 1'b0;
                  idx     <= '0;
               end
            end
            S_TURN: begin
               if (dir_edge) begin
                  turn_cnt <= TURN_LOAD;
               end else if (turn_cnt == 2'd0) begin
                  state <= dir ? S_RX : S_IDLE;
               end else begin
                  turn_cnt <= turn_cnt - 2'd1;
               end
            end
            S_RX: begin
               if (dir_edge) begin
                  state    <= S_TURN;
                  turn_cnt <= TURN_LOAD;
               end else if (nxt) begin
                  internal_data_out <= data_in;
                  new_byte          <= 1'b1;
               end else begin
                  rx_cmd       <= data_in;
                  rx_cmd_valid <= 1'b1;
               end
            end
            S_TX_CMD, S_TX_DATA: begin
               if (dir) begin
                  // PHY grabbed the bus: drop the packet, no stp.
                  state      <= S_TURN;
                  turn_cnt   <= TURN_LOAD;
                  tx_aborted <= 1'b1;
                  idx        <= '0;
               end else if (nxt) begin
                  if (state == S_TX_CMD) begin
                     state <= S_TX_DATA;
                     idx   <= '0;
                  end else if (idx == LAST_IDX) begin
                     state <= S_TX_STP;
                     idx   <= '0;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            end
            S_TX_STP: begin
               if (dir_edge) begin
                  state    <= S_TURN;
                  turn_cnt <= TURN_LOAD;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ulpi_link_fsm.sv
// Bench for ulpi_link_fsm: RX vector table, randomized RX against a register
// model, and transmit streams checked against a byte queue.
module tb_ulpi_link_fsm;

   localparam int TXB = 66;

   logic             clk = 1'b0;
   logic             n_rst = 1'b0;
   logic             dir = 1'b0;
   logic             nxt = 1'b0;
   logic [7:0]       data_in = 8'h00;
   logic [7:0]       data_out;
   logic             stp;
   logic             shift_out = 1'b0;
   logic [3:0]       tx_pid = 4'h0;
   logic [TXB*8-1:0] internal_data_in = '0;
   logic             tx_busy;
   logic             tx_done;
   logic             tx_aborted;
   logic             new_byte;
   logic [7:0]       internal_data_out;
   logic [7:0]       rx_cmd;
   logic             rx_cmd_valid;
   logic             rx_active;

   ulpi_link_fsm #(.TX_BYTES(TXB), .TURNAROUND(1)) dut (
      .clk(clk), .n_rst(n_rst), .dir(dir), .nxt(nxt), .data_in(data_in),
      .data_out(data_out), .stp(stp), .shift_out(shift_out), .tx_pid(tx_pid),
      .internal_data_in(internal_data_in), .tx_busy(tx_busy), .tx_done(tx_done),
      .tx_aborted(tx_aborted), .new_byte(new_byte),
      .internal_data_out(internal_data_out), .rx_cmd(rx_cmd),
      .rx_cmd_valid(rx_cmd_valid), .rx_active(rx_active)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] cur_pl [TXB];

   typedef struct {
      logic        dir;
      logic        nxt;
      logic [7:0]  din;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk(input logic [7:0] dout, input logic s, input logic busy,
                                      input logic done, input logic abt, input logic nb,
                                      input logic [7:0] ido, input logic [7:0] rxc,
                                      input logic vld, input logic act);
      return {1'b0, dout, s, busy, done, abt, nb, ido, rxc, vld, act};
   endfunction

   function automatic logic [31:0] snap();
      return {1'b0, data_out, stp, tx_busy, tx_done, tx_aborted, new_byte,
              internal_data_out, rx_cmd, rx_cmd_valid, rx_active};
   endfunction

   function automatic logic [TXB*8-1:0] pack();
      logic [TXB*8-1:0] v;
      v = '0;
      for (int i = 0; i < TXB; i++) v[(TXB-1-i)*8 +: 8] = cur_pl[i];
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Request a packet while IDLE with dir low; returns in the first TX_CMD cycle.
   task automatic start_tx(input logic [3:0] pid);
      shift_out        = 1'b1;
      tx_pid           = pid;
      internal_data_in = pack();
      step();
      shift_out = 1'b0;
      chk("accept_busy", 32'(tx_busy), 32'd1);
      chk("accept_idle_bus", 32'(data_out), 32'h00);
      step();
   endtask

   // Expected wire bytes: CMD byte, then payload; nxt=1 consumes the front.
   // mode 0: nxt held 1, 1: toggling, 2: random. abort_at: payload index to raise dir at.
   task automatic tx_stream(input logic [3:0] pid, input int mode, input int abort_at);
      logic [7:0] q[$];
      int  popped;
      bit  done;
      logic tog;
      q.push_back({4'b0100, pid});
      for (int i = 0; i < TXB; i++) q.push_back(cur_pl[i]);
      popped = 0;
      done   = 0;
      tog    = 1'b1;
      for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
         if (q.size() == 0) begin
            shift_out = 1'b0;
            chk("stp_cycle", {22'd0, data_out, stp, tx_done}, {22'd0, 8'h00, 1'b1, 1'b1});
            step();
            chk("after_stp", {29'd0, stp, tx_done, tx_busy}, 32'd0);
            done = 1;
         end else begin
            chk("tx_byte", {23'd0, data_out, stp}, {23'd0, q[0], 1'b0});
            if (abort_at >= 0 && popped == abort_at + 1) begin
               shift_out = 1'b0;
               dir = 1'b1;
               nxt = 1'b0;
               step();
               chk("abort_pulse", {28'd0, tx_aborted, stp, tx_busy, rx_active}, {28'd0, 4'b1000});
               step();
               chk("abort_to_rx", {30'd0, tx_aborted, rx_active}, 32'd1);
               dir = 1'b0;
               step();
               step();
               chk("abort_back_idle", {29'd0, rx_active, tx_busy, stp}, 32'd0);
               done = 1;
            end else begin
               case (mode)
                  0:       nxt = 1'b1;
                  1:       begin nxt = tog; tog = ~tog; end
                  default: nxt = 1'($urandom_range(0, 1));
               endcase
               shift_out = 1'($urandom_range(0, 1));
               tx_pid    = 4'($urandom);
               internal_data_in = ~internal_data_in;
               step();
               if (nxt) begin
                  void'(q.pop_front());
                  popped++;
               end
            end
         end
      end
      nxt = 1'b0;
      shift_out = 1'b0;
      if (!done) chk("tx_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      logic [7:0] e_rxc;
      logic [7:0] e_ido;
      logic       n;
      logic [7:0] d;

      vecs[0] = '{1'b0, 1'b0, 8'h00, mk(8'h00,0,0,0,0,0,8'h00,8'h00,0,0)};
      vecs[1] = '{1'b1, 1'b0, 8'hFF, mk(8'h00,0,0,0,0,0,8'h00,8'h00,0,0)};
      vecs[2] = '{1'b1, 1'b0, 8'hFF, mk(8'h00,0,0,0,0,0,8'h00,8'h00,0,1)};
      vecs[3] = '{1'b1, 1'b0, 8'hFF, mk(8'h00,0,0,0,0,0,8'h00,8'hFF,1,1)};
      vecs[4] = '{1'b1, 1'b0, 8'h10, mk(8'h00,0,0,0,0,0,8'h00,8'h10,1,1)};
      vecs[5] = '{1'b1, 1'b1, 8'hFF, mk(8'h00,0,0,0,0,1,8'hFF,8'h10,0,1)};
      vecs[6] = '{1'b1, 1'b1, 8'hAA, mk(8'h00,0,0,0,0,1,8'hAA,8'h10,0,1)};
      vecs[7] = '{1'b0, 1'b0, 8'h55, mk(8'h00,0,0,0,0,0,8'hAA,8'h10,0,0)};
      vecs[8] = '{1'b0, 1'b1, 8'h66, mk(8'h00,0,0,0,0,0,8'hAA,8'h10,0,0)};
      vecs[9] = '{1'b0, 1'b0, 8'h00, mk(8'h00,0,0,0,0,0,8'hAA,8'h10,0,0)};

      // Reset state and quiet cycles after release
      repeat (2) @(negedge clk);
      chk("in_reset", snap(), 32'd0);
      n_rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_reset", snap(), 32'd0);
      end

      // RX table: turnaround, RX CMD 0xFF, 0x10, data 0xFF, 0xAA, back to IDLE
      for (int i = 0; i < 10; i++) begin
         dir     = vecs[i].dir;
         nxt     = vecs[i].nxt;
         data_in = vecs[i].din;
         step();
         chk($sformatf("vec%0d", i), snap(), vecs[i].exp);
      end

      // Randomized RX traffic against a register model
      e_rxc = 8'h10;
      e_ido = 8'hAA;
      dir = 1'b1;
      nxt = 1'b0;
      step();
      chk("rnd_turn", 32'(rx_active), 32'd0);
      step();
      chk("rnd_rx", 32'(rx_active), 32'd1);
      for (int i = 0; i < 40; i++) begin
         n = 1'($urandom_range(0, 1));
         d = 8'($urandom);
         nxt = n;
         data_in = d;
         step();
         if (n) e_ido = d;
         else   e_rxc = d;
         chk("rnd_rx_cycle", {6'd0, new_byte, rx_cmd_valid, rx_cmd, internal_data_out, data_out},
             {6'd0, n, ~n, e_rxc, e_ido, 8'h00});
      end
      dir = 1'b0;
      nxt = 1'b0;
      step();
      step();
      chk("rnd_exit", {30'd0, rx_active, new_byte}, 32'd0);

      // 66-byte packet {AA,BB...}, pid 3, nxt held high
      for (int i = 0; i < TXB; i++) cur_pl[i] = (i % 2 == 0) ? 8'hAA : 8'hBB;
      start_tx(4'h3);
      tx_stream(4'h3, 0, -1);

      // Same packet with nxt toggling
      start_tx(4'h3);
      tx_stream(4'h3, 1, -1);

      // Random payload and pid, random throttling
      for (int i = 0; i < TXB; i++) cur_pl[i] = 8'($urandom);
      start_tx(4'hA);
      tx_stream(4'hA, 2, -1);

      // dir rises on the launch cycle: no launch, no abort, request survives
      shift_out = 1'b1;
      tx_pid = 4'h5;
      internal_data_in = pack();
      step();
      shift_out = 1'b0;
      dir = 1'b1;
      step();
      chk("launch_blocked", {29'd0, tx_aborted, tx_busy, rx_active}, 32'd2);
      step();
      chk("pending_in_rx", {30'd0, tx_busy, rx_active}, 32'd3);
      dir = 1'b0;
      step();
      step();
      chk("pending_idle", {23'd0, data_out, tx_busy}, {23'd0, 8'h00, 1'b1});
      step();
      tx_stream(4'h5, 0, -1);

      // Abort at byte 10, then a full packet from byte 0
      for (int i = 0; i < TXB; i++) cur_pl[i] = 8'(i + 1);
      start_tx(4'h9);
      tx_stream(4'h9, 0, 10);
      start_tx(4'h9);
      tx_stream(4'h9, 1, -1);

      // Reset in the middle of a packet
      start_tx(4'h2);
      nxt = 1'b1;
      repeat (5) step();
      #1 n_rst = 1'b0;
      #1 chk("reset_mid_tx", snap(), 32'd0);
      @(negedge clk);
      nxt = 1'b0;
      n_rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_reset_tx", snap(), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
